pht_predictor: RTL and testbench

- Parametrised branch pattern history table (PHT): 2^IDX_W saturating counters of CTR_W bits each, replacing the single-entry 2-bit predictor.
- Supports bimodal indexing and gshare indexing (index XOR global history register), with a 1-cycle registered lookup and a separate resolve/update port.
- Counts mispredictions in a saturating counter.
- Sits between fetch (lookup) and branch resolution (update) in the branch unit.

---
 rtl/pht_predictor.sv | 111 +++++++++++
 tb/tb_pht_predictor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pht_predictor.sv
// Pattern history table branch predictor: 2^IDX_W saturating counters indexed bimodally or by
// gshare, with a 1-cycle registered lookup, a resolve/update port and a saturating miss counter.
module pht_predictor #(
    parameter int unsigned CTR_W  = 2,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned GHR_W  = 4,
    parameter int unsigned MODE   = 0,
    parameter int unsigned INIT   = 0,
    parameter int unsigned MISS_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lookup_valid_i,
    input  logic [IDX_W-1:0]  lookup_idx_i,
    output logic              predict_valid_o,
    output logic              predict_taken_o,
    output logic [CTR_W-1:0]  predict_ctr_o,
    output logic [IDX_W-1:0]  predict_index_o,
    input  logic              update_valid_i,
    input  logic [IDX_W-1:0]  update_idx_i,
    input  logic              update_taken_i,
    output logic [GHR_W-1:0]  ghr_o,
    output logic [MISS_W-1:0] mismatch_o
);
    localparam int unsigned      Entries = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CtrMax  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CtrInit = CTR_W'(INIT);

    logic [CTR_W-1:0]  ctr_q [Entries];
    logic [GHR_W-1:0]  ghr_q, ghr_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              pvalid_q, pvalid_d;
    logic              ptaken_q, ptaken_d;
    logic [CTR_W-1:0]  pctr_q, pctr_d;
    logic [IDX_W-1:0]  pidx_q, pidx_d;

    logic [CTR_W-1:0]  upd_old, upd_new, lk_ctr;
    logic [IDX_W-1:0]  lk_idx;
    logic              mispredict;

    always_comb begin
        upd_old = ctr_q[update_idx_i];
        if (update_taken_i) begin
            upd_new = (upd_old == CtrMax) ? upd_old : upd_old + CTR_W'(1);
        end else begin
            upd_new = (upd_old == '0) ? upd_old : upd_old - CTR_W'(1);
        end
        mispredict = update_valid_i && (update_taken_i != upd_old[CTR_W-1]);

        // Hash with the history as it stands before this cycle's update shifts it.
        if (MODE == 1) begin
            lk_idx = lookup_idx_i ^ IDX_W'(ghr_q);
        end else begin
            lk_idx = lookup_idx_i;
        end
        // Same-index update forwards its post-update value into the lookup.
        lk_ctr = (update_valid_i && (update_idx_i == lk_idx)) ? upd_new : ctr_q[lk_idx];

        pvalid_d = lookup_valid_i;
        ptaken_d = ptaken_q;
        pctr_d   = pctr_q;
        pidx_d   = pidx_q;
        if (lookup_valid_i) begin
            pidx_d   = lk_idx;
            pctr_d   = lk_ctr;
            ptaken_d = lk_ctr[CTR_W-1];
        end

        ghr_d = ghr_q;
        if (update_valid_i) begin
            ghr_d = GHR_W'({ghr_q, update_taken_i});
        end

        miss_d = miss_q;
        if (mispredict && (miss_q != {MISS_W{1'b1}})) begin
            miss_d = miss_q + MISS_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                ctr_q[i] <= CtrInit;
            end
            ghr_q    <= '0;
            miss_q   <= '0;
            pvalid_q <= 1'b0;
            ptaken_q <= 1'b0;
            pctr_q   <= '0;
            pidx_q   <= '0;
        end else begin
            if (update_valid_i) begin
                ctr_q[update_idx_i] <= upd_new;
            end
            ghr_q    <= ghr_d;
            miss_q   <= miss_d;
            pvalid_q <= pvalid_d;
            ptaken_q <= ptaken_d;
            pctr_q   <= pctr_d;
            pidx_q   <= pidx_d;
        end
    end

    assign predict_valid_o = pvalid_q;
    assign predict_taken_o = ptaken_q;
    assign predict_ctr_o   = pctr_q;
    assign predict_index_o = pidx_q;
    assign ghr_o           = ghr_q;
    assign mismatch_o      = miss_q;

endmodule

// File: tb/tb_pht_predictor.sv
// Directed bench for pht_predictor: four instances cover bimodal, gshare, a narrow miss
// counter and a wide counter with non-zero INIT.
module tb_pht_predictor;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // a: defaults (bimodal)
    logic a_lv, a_pv, a_pt, a_uv, a_ut;
    logic [3:0] a_li, a_pi, a_ui, a_ghr;
    logic [1:0] a_pc;
    logic [15:0] a_mis;
    // b: gshare
    logic b_lv, b_pv, b_pt, b_uv, b_ut;
    logic [3:0] b_li, b_pi, b_ui, b_ghr;
    logic [1:0] b_pc;
    logic [15:0] b_mis;
    // c: 3-bit miss counter
    logic c_lv, c_pv, c_pt, c_uv, c_ut;
    logic [3:0] c_li, c_pi, c_ui, c_ghr;
    logic [1:0] c_pc;
    logic [2:0] c_mis;
    // d: 3-bit counters, INIT = 3
    logic d_lv, d_pv, d_pt, d_uv, d_ut;
    logic [3:0] d_li, d_pi, d_ui, d_ghr;
    logic [2:0] d_pc;
    logic [15:0] d_mis;

    pht_predictor u_a (
        .clk_i(clk), .rst_ni(rst_n), .lookup_valid_i(a_lv), .lookup_idx_i(a_li),
        .predict_valid_o(a_pv), .predict_taken_o(a_pt), .predict_ctr_o(a_pc),
        .predict_index_o(a_pi), .update_valid_i(a_uv), .update_idx_i(a_ui),
        .update_taken_i(a_ut), .ghr_o(a_ghr), .mismatch_o(a_mis)
    );
    pht_predictor #(.MODE(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .lookup_valid_i(b_lv), .lookup_idx_i(b_li),
        .predict_valid_o(b_pv), .predict_taken_o(b_pt), .predict_ctr_o(b_pc),
        .predict_index_o(b_pi), .update_valid_i(b_uv), .update_idx_i(b_ui),
        .update_taken_i(b_ut), .ghr_o(b_ghr), .mismatch_o(b_mis)
    );
    pht_predictor #(.MISS_W(3)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .lookup_valid_i(c_lv), .lookup_idx_i(c_li),
        .predict_valid_o(c_pv), .predict_taken_o(c_pt), .predict_ctr_o(c_pc),
        .predict_index_o(c_pi), .update_valid_i(c_uv), .update_idx_i(c_ui),
        .update_taken_i(c_ut), .ghr_o(c_ghr), .mismatch_o(c_mis)
    );
    pht_predictor #(.CTR_W(3), .INIT(3)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .lookup_valid_i(d_lv), .lookup_idx_i(d_li),
        .predict_valid_o(d_pv), .predict_taken_o(d_pt), .predict_ctr_o(d_pc),
        .predict_index_o(d_pi), .update_valid_i(d_uv), .update_idx_i(d_ui),
        .update_taken_i(d_ut), .ghr_o(d_ghr), .mismatch_o(d_mis)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_update(input logic [3:0] idx, input logic tk);
        a_uv = 1'b1; a_ui = idx; a_ut = tk;
        tick();
        a_uv = 1'b0;
    endtask

    task automatic a_lookup(input logic [3:0] idx);
        a_lv = 1'b1; a_li = idx;
        tick();
        a_lv = 1'b0;
    endtask

    task automatic b_update(input logic [3:0] idx, input logic tk);
        b_uv = 1'b1; b_ui = idx; b_ut = tk;
        tick();
        b_uv = 1'b0;
    endtask

    task automatic c_update(input logic [3:0] idx, input logic tk);
        c_uv = 1'b1; c_ui = idx; c_ut = tk;
        tick();
        c_uv = 1'b0;
    endtask

    task automatic d_lookup(input logic [3:0] idx);
        d_lv = 1'b1; d_li = idx;
        tick();
        d_lv = 1'b0;
    endtask

    int sat_up[5] = '{1, 2, 3, 3, 3};
    int sat_dn[4] = '{2, 1, 0, 0};

    initial begin
        rst_n = 1'b0;
        {a_lv, a_uv, a_ut, b_lv, b_uv, b_ut, c_lv, c_uv, c_ut, d_lv, d_uv, d_ut} = '0;
        {a_li, a_ui, b_li, b_ui, c_li, c_ui, d_li, d_ui} = '0;
        #2;
        check("rst_pv", a_pv, 0);
        check("rst_ghr", a_ghr, 0);
        check("rst_mis", a_mis, 0);
        check("rst_d_pc", d_pc, 0);
        #10 rst_n = 1'b1;

        // Saturating count up and down on index 3
        for (int i = 0; i < 5; i++) begin
            a_update(4'd3, 1'b1);
            a_lookup(4'd3);
            check("sat_up_ctr", a_pc, sat_up[i]);
        end
        check("sat_up_pv", a_pv, 1);
        check("sat_up_pi", a_pi, 3);
        check("sat_up_mis", a_mis, 2);
        check("sat_up_ghr", a_ghr, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            a_update(4'd3, 1'b0);
            a_lookup(4'd3);
            check("sat_dn_ctr", a_pc, sat_dn[i]);
        end
        check("sat_dn_mis", a_mis, 4);
        check("sat_dn_ghr", a_ghr, 4'b0000);

        // Idle cycle: valid drops, payload holds
        a_lookup(4'd3);
        tick();
        check("idle_pv", a_pv, 0);
        check("idle_pi", a_pi, 3);

        // Forwarding on a same-index lookup and update
        a_update(4'd7, 1'b1);
        check("fwd_pre_mis", a_mis, 5);
        a_lv = 1'b1; a_li = 4'd7; a_uv = 1'b1; a_ui = 4'd7; a_ut = 1'b1;
        tick();
        a_lv = 1'b0; a_uv = 1'b0;
        check("fwd_ctr", a_pc, 2);
        check("fwd_taken", a_pt, 1);
        check("fwd_mis", a_mis, 6);
        a_lv = 1'b1; a_li = 4'd3; a_uv = 1'b1; a_ui = 4'd7; a_ut = 1'b1;
        tick();
        a_lv = 1'b0; a_uv = 1'b0;
        check("indep_ctr", a_pc, 0);
        check("indep_pi", a_pi, 3);
        check("indep_ghr", a_ghr, 4'b0111);

        // Gshare indexing
        b_update(4'd0, 1'b1);
        b_update(4'd0, 1'b1);
        b_update(4'd0, 1'b0);
        b_update(4'd0, 1'b1);
        check("gs_ghr", b_ghr, 4'b1101);
        b_lv = 1'b1; b_li = 4'b0110;
        tick();
        b_lv = 1'b0;
        check("gs_pi", b_pi, 4'b1011);
        check("gs_pv", b_pv, 1);
        b_lv = 1'b1; b_li = 4'b0110; b_uv = 1'b1; b_ui = 4'd0; b_ut = 1'b1;
        tick();
        b_lv = 1'b0; b_uv = 1'b0;
        check("gs_preshift_pi", b_pi, 4'b1011);
        check("gs_shift_ghr", b_ghr, 4'b1011);

        // Miss counter saturation: every update below mispredicts
        c_update(4'd0, 1'b1);
        check("mis_sat_first", c_mis, 1);
        for (int i = 0; i < 10; i++) begin
            c_update(4'd0, (i % 2) == 0);
            check("mis_sat", c_mis, (i + 2 > 7) ? 7 : i + 2);
        end

        // Wide counter with INIT = 3
        d_lookup(4'd2);
        check("wide_init_ctr", d_pc, 3);
        check("wide_init_taken", d_pt, 0);
        d_uv = 1'b1; d_ui = 4'd2; d_ut = 1'b1;
        tick();
        d_uv = 1'b0;
        check("wide_mis", d_mis, 1);
        d_lookup(4'd2);
        check("wide_ctr", d_pc, 4);
        check("wide_taken", d_pt, 1);

        // Asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pv", a_pv, 0);
        check("mid_rst_pt", a_pt, 0);
        check("mid_rst_pi", a_pi, 0);
        check("mid_rst_pc", a_pc, 0);
        check("mid_rst_ghr", a_ghr, 0);
        check("mid_rst_mis", a_mis, 0);
        check("mid_rst_d_pc", d_pc, 0);
        #2 rst_n = 1'b1;
        a_lookup(4'd5);
        check("post_rst_pv", a_pv, 1);
        check("post_rst_pc", a_pc, 0);
        check("post_rst_pt", a_pt, 0);
        a_lookup(4'd7);
        check("post_rst_ctr7", a_pc, 0);
        d_lookup(4'd2);
        check("post_rst_d_init", d_pc, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
